// File: rtl/load_writeback.sv
// Writeback stage: turns completed ALU results and data-memory loads into byte-granular
// register-file writes. Loads park in WAIT_MEM until read data arrives, then the word is
// aligned/extended and written. All register-file outputs are registered on the rising
// edge so the register file can sample them on the following falling edge.
module load_writeback #(
    parameter int unsigned ADDR_WIDTH = 5,
    parameter int unsigned DATA_WIDTH = 32
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [2:0]            mem_op,
    input  logic [1:0]            addr_lo,
    input  logic [ADDR_WIDTH-1:0] dest,
    input  logic [DATA_WIDTH-1:0] alu_result,
    input  logic [DATA_WIDTH-1:0] mem_rdata,
    input  logic                  mem_rvalid,
    output logic                  write,
    output logic [ADDR_WIDTH-1:0] Rd_addr,
    output logic [DATA_WIDTH-1:0] Rd_in,
    output logic [3:0]            Rd_Byte_w_en,
    output logic                  misalign
);

    localparam logic [2:0] OpAlu = 3'd0;
    localparam logic [2:0] OpLb  = 3'd1;
    localparam logic [2:0] OpLbu = 3'd2;
    localparam logic [2:0] OpLh  = 3'd3;
    localparam logic [2:0] OpLhu = 3'd4;
    localparam logic [2:0] OpLw  = 3'd5;
    localparam logic [2:0] OpLwl = 3'd6;
    localparam logic [2:0] OpLwr = 3'd7;

    typedef enum logic [0:0] {
        StIdle,
        StWaitMem
    } state_e;

    state_e                state_q, state_d;
    logic [2:0]            op_q, op_d;
    logic [1:0]            a_q, a_d;
    logic [ADDR_WIDTH-1:0] dest_q, dest_d;
    logic                  write_q, write_d;
    logic [ADDR_WIDTH-1:0] rd_addr_q, rd_addr_d;
    logic [DATA_WIDTH-1:0] rd_in_q, rd_in_d;
    logic [3:0]            ben_q, ben_d;
    logic                  misalign_q, misalign_d;

    // Aligned load result for the op latched at accept.
    logic [7:0]            byte_sel;
    logic [15:0]           half_sel;
    logic [DATA_WIDTH-1:0] load_data;
    logic [3:0]            load_ben;
    logic                  load_misalign;

    // Select byte/halfword lanes and build the aligned load data and byte enables.
    always_comb begin
        byte_sel      = mem_rdata[7:0];
        half_sel      = a_q[1] ? mem_rdata[31:16] : mem_rdata[15:0];
        load_data     = mem_rdata;
        load_ben      = 4'b0000;
        load_misalign = 1'b0;

        case (a_q)
            2'd0:    byte_sel = mem_rdata[7:0];
            2'd1:    byte_sel = mem_rdata[15:8];
            2'd2:    byte_sel = mem_rdata[23:16];
            default: byte_sel = mem_rdata[31:24];
        endcase

        case (op_q)
            OpLb:  load_data = {{24{byte_sel[7]}}, byte_sel};
            OpLbu: load_data = {24'h0, byte_sel};
            OpLh, OpLhu: begin
                if (op_q == OpLh) begin
                    load_data = {{16{half_sel[15]}}, half_sel};
                end else begin
                    load_data = {16'h0, half_sel};
                end
                // Odd halfword address: suppress the write entirely.
                if (a_q[0]) begin
                    load_misalign = 1'b1;
                    load_ben      = 4'b1111;
                end
            end
            OpLw:  load_data = mem_rdata;
            OpLwl: begin
                // Upper bytes of the destination get the low bytes of the memory word.
                case (a_q)
                    2'd0: begin
                        load_data = {mem_rdata[7:0], 24'h0};
                        load_ben  = 4'b0111;
                    end
                    2'd1: begin
                        load_data = {mem_rdata[15:0], 16'h0};
                        load_ben  = 4'b0011;
                    end
                    2'd2: begin
                        load_data = {mem_rdata[23:0], 8'h0};
                        load_ben  = 4'b0001;
                    end
                    default: begin
                        load_data = mem_rdata;
                        load_ben  = 4'b0000;
                    end
                endcase
            end
            OpLwr: begin
                // Lower bytes of the destination get the high bytes of the memory word.
                case (a_q)
                    2'd0: begin
                        load_data = mem_rdata;
                        load_ben  = 4'b0000;
                    end
                    2'd1: begin
                        load_data = {8'h0, mem_rdata[31:8]};
                        load_ben  = 4'b1000;
                    end
                    2'd2: begin
                        load_data = {16'h0, mem_rdata[31:16]};
                        load_ben  = 4'b1100;
                    end
                    default: begin
                        load_data = {24'h0, mem_rdata[31:24]};
                        load_ben  = 4'b1110;
                    end
                endcase
            end
            default: load_data = mem_rdata;
        endcase
    end

    // Next-state: accept in IDLE, complete loads on mem_rvalid in WAIT_MEM.
    always_comb begin
        state_d    = state_q;
        op_d       = op_q;
        a_d        = a_q;
        dest_d     = dest_q;
        rd_addr_d  = rd_addr_q;
        rd_in_d    = rd_in_q;
        ben_d      = ben_q;
        write_d    = 1'b0;
        misalign_d = 1'b0;

        case (state_q)
            StIdle: begin
                if (in_valid) begin
                    op_d   = mem_op;
                    a_d    = addr_lo;
                    dest_d = dest;
                    if (mem_op == OpAlu) begin
                        write_d   = (dest != '0);
                        rd_addr_d = dest;
                        rd_in_d   = alu_result;
                        ben_d     = 4'b0000;
                    end else begin
                        state_d = StWaitMem;
                    end
                end
            end
            StWaitMem: begin
                if (mem_rvalid) begin
                    state_d    = StIdle;
                    write_d    = (dest_q != '0) && !load_misalign;
                    misalign_d = load_misalign;
                    rd_addr_d  = dest_q;
                    rd_in_d    = load_data;
                    ben_d      = load_ben;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    // State and registered register-file outputs.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q    <= StIdle;
            op_q       <= OpAlu;
            a_q        <= 2'd0;
            dest_q     <= '0;
            write_q    <= 1'b0;
            rd_addr_q  <= '0;
            rd_in_q    <= '0;
            ben_q      <= 4'b1111;
            misalign_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            op_q       <= op_d;
            a_q        <= a_d;
            dest_q     <= dest_d;
            write_q    <= write_d;
            rd_addr_q  <= rd_addr_d;
            rd_in_q    <= rd_in_d;
            ben_q      <= ben_d;
            misalign_q <= misalign_d;
        end
    end

    assign in_ready     = (state_q == StIdle);
    assign write        = write_q;
    assign Rd_addr      = rd_addr_q;
    assign Rd_in        = rd_in_q;
    assign Rd_Byte_w_en = ben_q;
    assign misalign     = misalign_q;

endmodule
